// File: rtl/lcd_nibble_feeder.sv
// -----------------------------------------------------------------------------
// lcd_nibble_feeder
//
// Streams one LCD line of 4-bit pixel data out of a byte-wide framebuffer.
// The timing stage announces frames (frame_start), lines (line_start) and
// individual CL2 shifts (shift_tick). For every line this block reads the
// line's bytes in order, splits each one into high nibble then low nibble,
// and presents the current nibble on lcd_d so that each shift_tick consumes
// exactly one nibble.
//
// Parameters
//   NIBBLES : CL2 shifts per line (must be even)
//   LINES   : lines per frame
//   ADDR_W  : framebuffer byte-address width, 2**ADDR_W >= LINES*NIBBLES/2
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   frame_start in   1-clk pulse, rewinds the line counter to 0
//   line_start  in   1-clk pulse, begins the next line (aborts a busy one)
//   shift_tick  in   1-clk pulse, consumes the nibble currently on lcd_d
//   fb_rd       out  framebuffer read strobe
//   fb_addr     out  framebuffer byte address, valid while fb_rd is high
//   fb_data     in   read data, valid exactly one clk after fb_rd
//   lcd_d       out  current nibble D3..D0 (0 when no real pixel is held)
//   data_valid  out  lcd_d holds a real pixel nibble
//   line_busy   out  a line is in progress
//   underrun    out  sticky: a nibble was consumed before it was available,
//                    or a line was aborted by a new line_start
// -----------------------------------------------------------------------------
module lcd_nibble_feeder #(
   parameter int NIBBLES = 240,
   parameter int LINES   = 32,
   parameter int ADDR_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              line_start,
   input  logic              shift_tick,
   output logic              fb_rd,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [7:0]        fb_data,
   output logic [3:0]        lcd_d,
   output logic              data_valid,
   output logic              line_busy,
   output logic              underrun
);

   // Bytes per line, and counter widths sized so that NIBBLES-1, NB and
   // LINES-1 are all representable.
   localparam int NB    = NIBBLES / 2;
   localparam int NIB_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
   localparam int BI_W  = $clog2(NB + 1);
   localparam int LI_W  = (LINES > 1) ? $clog2(LINES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   state_t            state_q,      state_d;
   logic [LI_W-1:0]   line_idx_q,   line_idx_d;
   logic [ADDR_W-1:0] base_q,       base_d;
   logic [NIB_W-1:0]  nib_q,        nib_d;      // nibble now presented
   logic [BI_W-1:0]   rd_idx_q,     rd_idx_d;   // next byte to request
   logic [BI_W-1:0]   arr_idx_q,    arr_idx_d;  // byte index of next return
   logic [7:0]        cur_q,        cur_d;      // byte holding nibble nib_q
   logic              cur_vld_q,    cur_vld_d;
   logic [7:0]        pf_q,         pf_d;       // prefetched following byte
   logic              pf_vld_q,     pf_vld_d;
   logic              fb_rd_q,      fb_rd_d;
   logic [ADDR_W-1:0] fb_addr_q,    fb_addr_d;
   logic              ack_q,        ack_d;      // fb_data is valid this clk
   logic [3:0]        lcd_d_q,      lcd_d_d;
   logic              data_valid_q, data_valid_d;
   logic              line_busy_q,  line_busy_d;
   logic              underrun_q,   underrun_d;

   // Working copies inside the next-state logic. Each event of the clk is
   // applied in order: tick first (it frees buffer space and moves the
   // nibble pointer), then the returning byte, then the read decision.
   logic [LI_W-1:0]   li;
   logic [NIB_W-1:0]  n;
   logic [BI_W-1:0]   need_idx;
   logic [7:0]        c;
   logic              c_vld;
   logic [7:0]        p;
   logic              p_vld;
   logic              line_done;

   always_comb begin
      state_d      = state_q;
      line_idx_d   = line_idx_q;
      base_d       = base_q;
      nib_d        = nib_q;
      rd_idx_d     = rd_idx_q;
      arr_idx_d    = arr_idx_q;
      cur_d        = cur_q;
      cur_vld_d    = cur_vld_q;
      pf_d         = pf_q;
      pf_vld_d     = pf_vld_q;
      fb_rd_d      = 1'b0;
      fb_addr_d    = fb_addr_q;
      ack_d        = 1'b0;
      lcd_d_d      = lcd_d_q;
      data_valid_d = data_valid_q;
      underrun_d   = underrun_q;

      // frame_start takes effect before a coincident line_start.
      li        = frame_start ? '0 : line_idx_q;
      n         = nib_q;
      need_idx  = '0;
      c         = cur_q;
      c_vld     = cur_vld_q;
      p         = pf_q;
      p_vld     = pf_vld_q;
      line_done = 1'b0;

      if (frame_start) begin
         line_idx_d = '0;
      end

      if (line_start) begin
         // A new line always wins. Anything still buffered or in flight for
         // the old line is dropped: the ack pipeline is cleared, so a byte
         // returning next clk is never captured.
         if (state_q != IDLE) begin
            underrun_d = 1'b1;
         end
         base_d       = ADDR_W'(li) * ADDR_W'(NB);
         line_idx_d   = (li == LI_W'(LINES - 1)) ? '0 : li + 1'b1;
         state_d      = FILL;
         nib_d        = '0;
         rd_idx_d     = BI_W'(1);
         arr_idx_d    = '0;
         cur_vld_d    = 1'b0;
         pf_vld_d     = 1'b0;
         fb_rd_d      = 1'b1;
         fb_addr_d    = base_d;
         lcd_d_d      = 4'h0;
         data_valid_d = 1'b0;
      end else if (state_q != IDLE) begin
         // --- consume a nibble ---------------------------------------------
         if (shift_tick) begin
            if (!data_valid_q) begin
               underrun_d = 1'b1;
            end
            if (nib_q == NIB_W'(NIBBLES - 1)) begin
               line_done = 1'b1;
            end else begin
               n = nib_q + 1'b1;
               // Leaving a low nibble finishes the byte; the prefetch
               // (if it has arrived) becomes the current byte.
               if (nib_q[0]) begin
                  c     = p;
                  c_vld = p_vld;
                  p_vld = 1'b0;
               end
            end
         end

         if (line_done) begin
            state_d      = IDLE;
            nib_d        = '0;
            cur_vld_d    = 1'b0;
            pf_vld_d     = 1'b0;
            lcd_d_d      = 4'h0;
            data_valid_d = 1'b0;
         end else begin
            // --- accept the returning byte --------------------------------
            // Bytes come back in request order. A byte whose nibbles were
            // already skipped by underrun ticks is simply discarded.
            need_idx = BI_W'(n >> 1);
            if (ack_q) begin
               arr_idx_d = arr_idx_q + 1'b1;
               if (arr_idx_q == need_idx) begin
                  c     = fb_data;
                  c_vld = 1'b1;
               end else if (arr_idx_q > need_idx) begin
                  p     = fb_data;
                  p_vld = 1'b1;
               end
            end

            // --- issue the next read --------------------------------------
            // Only when nothing is in flight after this clk's return and the
            // prefetch slot is free, which bounds buffering to two bytes.
            if (!fb_rd_q && !p_vld && (rd_idx_q < BI_W'(NB))) begin
               fb_rd_d   = 1'b1;
               fb_addr_d = base_q + ADDR_W'(rd_idx_q);
               rd_idx_d  = rd_idx_q + 1'b1;
            end
            ack_d = fb_rd_q;

            if ((state_q == FILL) && c_vld) begin
               state_d = RUN;
            end

            nib_d        = n;
            cur_d        = c;
            cur_vld_d    = c_vld;
            pf_d         = p;
            pf_vld_d     = p_vld;
            lcd_d_d      = c_vld ? (n[0] ? c[3:0] : c[7:4]) : 4'h0;
            data_valid_d = c_vld;
         end
      end

      line_busy_d = (state_d != IDLE);
   end

   // ---------------------------------------------------------------------
   // Registers: state machine, buffers and all outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         line_idx_q   <= '0;
         base_q       <= '0;
         nib_q        <= '0;
         rd_idx_q     <= '0;
         arr_idx_q    <= '0;
         cur_q        <= '0;
         cur_vld_q    <= 1'b0;
         pf_q         <= '0;
         pf_vld_q     <= 1'b0;
         fb_rd_q      <= 1'b0;
         fb_addr_q    <= '0;
         ack_q        <= 1'b0;
         lcd_d_q      <= 4'h0;
         data_valid_q <= 1'b0;
         line_busy_q  <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_idx_q   <= line_idx_d;
         base_q       <= base_d;
         nib_q        <= nib_d;
         rd_idx_q     <= rd_idx_d;
         arr_idx_q    <= arr_idx_d;
         cur_q        <= cur_d;
         cur_vld_q    <= cur_vld_d;
         pf_q         <= pf_d;
         pf_vld_q     <= pf_vld_d;
         fb_rd_q      <= fb_rd_d;
         fb_addr_q    <= fb_addr_d;
         ack_q        <= ack_d;
         lcd_d_q      <= lcd_d_d;
         data_valid_q <= data_valid_d;
         line_busy_q  <= line_busy_d;
         underrun_q   <= underrun_d;
      end
   end

   assign fb_rd      = fb_rd_q;
   assign fb_addr    = fb_addr_q;
   assign lcd_d      = lcd_d_q;
   assign data_valid = data_valid_q;
   assign line_busy  = line_busy_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_lcd_nibble_feeder.sv
// -----------------------------------------------------------------------------
// tb_lcd_nibble_feeder
//
// Directed bench for lcd_nibble_feeder with a scoreboard. Stimulus pushes the
// expected nibble for every shift_tick and the expected address for every
// framebuffer read; a monitor on the falling edge pops and compares whenever
// the DUT consumes a nibble (shift_tick while line_busy) or issues fb_rd.
// A small framebuffer model answers reads one clk later.
// -----------------------------------------------------------------------------
module tb_lcd_nibble_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        line_start = 1'b0;
   logic        shift_tick = 1'b0;
   logic        fb_rd;
   logic [11:0] fb_addr;
   logic [7:0]  fb_data = 8'hEE;
   logic [3:0]  lcd_d;
   logic        data_valid;
   logic        line_busy;
   logic        underrun;

   lcd_nibble_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .line_start (line_start),
      .shift_tick (shift_tick),
      .fb_rd      (fb_rd),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .lcd_d      (lcd_d),
      .data_valid (data_valid),
      .line_busy  (line_busy),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   // Framebuffer model: data for a read appears exactly one clk later,
   // filler value otherwise so a mistimed capture is visible.
   logic [7:0] mem [0:4095];
   always @(posedge clk) begin
      fb_data <= (fb_rd === 1'b1) ? mem[fb_addr] : 8'hEE;
   end

   typedef struct packed {
      logic       v;
      logic [3:0] n;
   } exp_t;

   exp_t exp_nib[$];
   int   exp_addr[$];
   int   total = 0;
   int   bad = 0;
   int   rd_count = 0;
   bit   rd_chk = 1'b0;
   int   li_m = 0;
   int   base = 0;
   exp_t mon_e;
   int   mon_a;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [3:0] n);
      exp_t e;
      e.v = v;
      e.n = n;
      return e;
   endfunction

   function automatic logic [3:0] nib_of(input int b, input int k);
      logic [7:0] byt;
      byt = mem[(b + k / 2) % 4096];
      return (k % 2 == 0) ? byt[7:4] : byt[3:0];
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (shift_tick && (line_busy === 1'b1)) begin
            if (exp_nib.size() == 0) begin
               total++;
               bad++;
               $display("FAIL nib_extra: consumed lcd_d=%0h, expected no nibble", lcd_d);
            end else begin
               mon_e = exp_nib.pop_front();
               chk("nib_valid", int'(data_valid), int'(mon_e.v));
               chk("nib_data", int'(lcd_d), int'(mon_e.n));
            end
         end
         if (fb_rd === 1'b1) begin
            rd_count++;
            if (rd_chk) begin
               if (exp_addr.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rd_extra: read at fb_addr=%0d, expected no read", fb_addr);
               end else begin
                  mon_a = exp_addr.pop_front();
                  chk("rd_addr", int'(fb_addr), mon_a);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts a line at the current cycle t; returns in cycle t+1.
   task automatic begin_line(input bit with_fs, input bit chk_reads, output int b);
      if (with_fs) begin
         li_m = 0;
         frame_start = 1'b1;
      end
      b = (li_m * 120) % 4096;
      li_m = (li_m + 1) % 32;
      rd_chk = chk_reads;
      exp_addr.delete();
      if (chk_reads) begin
         for (int i = 0; i < 120; i++) exp_addr.push_back((b + i) % 4096);
      end
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic run_ticks(input int b, input int k0, input int k1, input int gap);
      for (int k = k0; k <= k1; k++) begin
         exp_nib.push_back(mk(1'b1, nib_of(b, k)));
         shift_tick = 1'b1;
         step();
         shift_tick = 1'b0;
         repeat (gap - 1) step();
      end
   endtask

   task automatic end_line_checks(input string tag, input int exp_under);
      @(negedge clk);
      chk({tag, "_busy_low"}, int'(line_busy), 0);
      chk({tag, "_dv_low"}, int'(data_valid), 0);
      chk({tag, "_lcd_zero"}, int'(lcd_d), 0);
      chk({tag, "_underrun"}, int'(underrun), exp_under);
      chk({tag, "_nib_left"}, exp_nib.size(), 0);
      if (rd_chk) chk({tag, "_rd_left"}, exp_addr.size(), 0);
      $display("%s line complete: checks=%0d bad=%0d", tag, total, bad);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = i[7:0];

      // ---- reset values ---------------------------------------------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_fb_rd", int'(fb_rd), 0);
      chk("rst_fb_addr", int'(fb_addr), 0);
      chk("rst_lcd_d", int'(lcd_d), 0);
      chk("rst_dv", int'(data_valid), 0);
      chk("rst_busy", int'(line_busy), 0);
      chk("rst_underrun", int'(underrun), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // ---- s1: first-line latency, byte 0 = 0xA5 -------------------------
      mem[0] = 8'hA5;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      li_m = 0;
      step();
      step();
      begin_line(1'b0, 1'b1, base);           // cycle t+1
      @(negedge clk);
      chk("s1_fb_rd_t1", int'(fb_rd), 1);
      chk("s1_fb_addr_t1", int'(fb_addr), 0);
      step();                                 // t+2
      @(negedge clk);
      chk("s1_dv_t2", int'(data_valid), 0);
      step();                                 // t+3
      @(negedge clk);
      chk("s1_dv_t3", int'(data_valid), 1);
      chk("s1_lcd_t3", int'(lcd_d), 4'hA);
      step();                                 // t+4
      exp_nib.push_back(mk(1'b1, 4'hA));
      shift_tick = 1'b1;
      step();
      shift_tick = 1'b0;
      @(negedge clk);
      chk("s1_lcd_after_tick", int'(lcd_d), 4'h5);
      step();
      step();
      run_ticks(0, 1, 239, 3);
      end_line_checks("s1", 0);
      mem[0] = 8'h00;

      // ---- s2: full slow line, frame_start together with line_start -------
      step();
      rd_count = 0;
      begin_line(1'b1, 1'b1, base);
      step();
      step();
      step();
      run_ticks(base, 0, 239, 100);
      end_line_checks("s2", 0);
      chk("s2_read_count", rd_count, 120);

      // ---- s3: line after coincident frame/line start uses index 1 --------
      step();
      begin_line(1'b0, 1'b1, base);
      @(negedge clk);
      chk("s3_idx1_base", int'(fb_addr), 120);
      step();
      step();
      step();
      run_ticks(base, 0, 239, 3);
      end_line_checks("s3", 0);

      // ---- s3w: 32 lines then one more, wrap to base 0 -------------------
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      li_m = 0;
      for (int ln = 0; ln < 33; ln++) begin
         step();
         begin_line(1'b0, 1'b1, base);
         @(negedge clk);
         if (ln == 31) chk("s3w_line31_base", int'(fb_addr), 3720);
         if (ln == 32) chk("s3w_line32_base", int'(fb_addr), 0);
         step();
         step();
         step();
         run_ticks(base, 0, 239, 3);
         end_line_checks("s3w", 0);
      end

      // ---- s4: tick one clk after line_start -> underrun ----------------
      step();
      begin_line(1'b1, 1'b1, base);           // t+1
      exp_nib.push_back(mk(1'b0, 4'h0));
      shift_tick = 1'b1;
      step();                                 // t+2
      shift_tick = 1'b0;
      @(negedge clk);
      chk("s4_underrun_set", int'(underrun), 1);
      step();
      step();                                 // t+4
      run_ticks(base, 1, 239, 3);
      end_line_checks("s4", 1);

      // ---- reset clears sticky underrun ----------------------------------
      rst = 1'b1;
      step();
      rst = 1'b0;
      li_m = 0;
      @(negedge clk);
      chk("rst2_underrun", int'(underrun), 0);

      // ---- s5: abort at nibble 57 ----------------------------------------
      step();
      begin_line(1'b0, 1'b0, base);
      step();
      step();
      step();
      run_ticks(base, 0, 56, 3);
      step();
      step();
      begin_line(1'b0, 1'b1, base);           // abort; new base 120
      @(negedge clk);
      chk("s5_underrun", int'(underrun), 1);
      chk("s5_fb_rd", int'(fb_rd), 1);
      chk("s5_fb_addr", int'(fb_addr), 120);
      chk("s5_dv_t1", int'(data_valid), 0);
      chk("s5_lcd_t1", int'(lcd_d), 0);
      step();
      @(negedge clk);
      chk("s5_dv_t2", int'(data_valid), 0);
      chk("s5_lcd_t2", int'(lcd_d), 0);
      step();
      @(negedge clk);
      chk("s5_dv_t3", int'(data_valid), 1);
      chk("s5_lcd_t3", int'(lcd_d), 4'h7);
      step();
      run_ticks(base, 0, 239, 3);
      end_line_checks("s5", 1);

      // ---- s6: reset at nibble 100 with a read in flight ------------------
      rst = 1'b1;
      step();
      rst = 1'b0;
      li_m = 0;
      step();
      begin_line(1'b0, 1'b0, base);
      step();
      step();
      step();
      run_ticks(base, 0, 98, 3);
      exp_nib.push_back(mk(1'b1, nib_of(base, 99)));
      shift_tick = 1'b1;
      step();
      shift_tick = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("s6_read_in_flight", int'(fb_rd), 1);
      step();
      rst = 1'b0;
      li_m = 0;
      @(negedge clk);
      chk("s6_fb_rd", int'(fb_rd), 0);
      chk("s6_fb_addr", int'(fb_addr), 0);
      chk("s6_lcd", int'(lcd_d), 0);
      chk("s6_dv", int'(data_valid), 0);
      chk("s6_busy", int'(line_busy), 0);
      chk("s6_underrun", int'(underrun), 0);
      step();
      @(negedge clk);
      chk("s6_dv_after", int'(data_valid), 0);
      chk("s6_lcd_after", int'(lcd_d), 0);
      chk("s6_nib_left", exp_nib.size(), 0);
      step();
      begin_line(1'b0, 1'b1, base);
      @(negedge clk);
      chk("s6_next_rd", int'(fb_rd), 1);
      chk("s6_next_addr", int'(fb_addr), 0);
      step();
      step();
      step();
      run_ticks(base, 0, 239, 3);
      end_line_checks("s6", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_nibble_feeder.md
LCD_NIBBLE_FEEDER -- requirements
Module: lcd_nibble_feeder

Interface
REQ-001 SHALL have parameter NIBBLES, default 240: CL2 shifts per LCD line. It SHALL be even.
REQ-002 SHALL have parameter LINES, default 32: lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 12: framebuffer byte-address width. It SHALL satisfy 2^ADDR_W >= LINES*NIBBLES/2.
REQ-004 SHALL have port clk, input, 1: single clock for all logic, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port frame_start, input, 1: one-clk pulse from the timing stage at FLM assertion.
REQ-007 SHALL have port line_start, input, 1: one-clk pulse from the timing stage at the CL1 falling edge, which begins the next line.
REQ-008 SHALL have port shift_tick, input, 1: one-clk pulse one clk before the CL2 falling edge, which advances one nibble.
REQ-009 SHALL have port fb_rd, output, 1: framebuffer read strobe.
REQ-010 SHALL have port fb_addr, output, ADDR_W: framebuffer byte address, valid while fb_rd is high.
REQ-011 SHALL have port fb_data, input, 8: read data, valid exactly 1 clk after fb_rd.
REQ-012 SHALL have port lcd_d, output, 4: LCD data nibble, D3..D0.
REQ-013 SHALL have port data_valid, output, 1: high when lcd_d holds a real pixel nibble.
REQ-014 SHALL have port line_busy, output, 1: high from line_start until the last nibble of the line is consumed.
REQ-015 SHALL have port underrun, output, 1: sticky error flag.

Function
REQ-016 SHALL implement states IDLE, FILL and RUN.
- IDLE to FILL on line_start.
- FILL to RUN when the first byte is captured.
- RUN to IDLE when shift_tick consumes nibble NIBBLES-1.
REQ-017 SHALL keep a line counter line_idx (0..LINES-1).
- frame_start sets line_idx=0.
- Each line_start uses the current line_idx, then increments it; it wraps LINES-1 to 0.
REQ-018 If frame_start and line_start occur in the same clk, frame_start SHALL apply first, so the line uses line_idx 0 and line_idx becomes 1.
REQ-019 Line base address SHALL be line_idx*(NIBBLES/2). Bytes within a line SHALL be read at base, base+1, ..., base+NIBBLES/2-1.
REQ-020 Nibble order SHALL be fb_data[7:4] first, then fb_data[3:0].
REQ-021 Line-start latency SHALL be as follows, for line_start at clk t:
- fb_rd=1 at t+1, with fb_addr=base.
- Byte captured at t+2.
- lcd_d = high nibble and data_valid=1 from t+3.
REQ-022 SHALL hold one current byte plus a one-byte prefetch register. The next byte SHALL be read as soon as the prefetch register is empty and bytes remain in the line.
REQ-023 At most one fb_rd SHALL be outstanding, and no read SHALL be issued beyond the last byte of the line.
REQ-024 A shift_tick in RUN SHALL update lcd_d to the next nibble in the following clk.
- On a low-nibble tick, the prefetched byte SHALL become the current byte.
REQ-025 The timing stage guarantees shift_tick spacing >= 3 clk. Under that condition, no underrun SHALL occur after FILL.
REQ-026 A shift_tick with data_valid=0 while line_busy=1 SHALL set underrun. The nibble count SHALL still advance and lcd_d SHALL be driven 0 for that nibble.
REQ-027 A shift_tick in IDLE SHALL be ignored and SHALL NOT set underrun.
REQ-028 A line_start while line_busy=1 SHALL abort the current line:
- Discard buffered bytes.
- Set underrun.
- Start the new line per REQ-021.
- Any in-flight fb_data for the aborted line SHALL be dropped.
REQ-029 After the last nibble is consumed, lcd_d SHALL be 0 and data_valid=0 until the next line's first nibble.
REQ-030 Nibble counter width SHALL be sufficient for NIBBLES-1 without overflow. Address arithmetic SHALL be modulo 2^ADDR_W.

Reset
REQ-031 rst SHALL be sampled only on a rising clk edge and SHALL override all other inputs.
REQ-032 On reset:
- State = IDLE.
- line_idx=0, fb_rd=0, fb_addr=0, lcd_d=0.
- data_valid=0, line_busy=0, underrun=0.
- Both byte buffers empty.
REQ-033 Reset mid-line SHALL drop the line; fb_data returning in the clk after reset SHALL be ignored.

Verification
REQ-034 Scenario: frame_start, then line_start at t=10, with fb byte 0 = 0xA5 -> fb_rd=1, fb_addr=0 at t=11; lcd_d=0xA, data_valid=1 at t=13; after a shift_tick, lcd_d=0x5.
REQ-035 Scenario: full line, shift_tick every 100 clk, fb[n]=n -> 240 nibbles in order 0,0,0,1,...,7,7; exactly 120 reads, addrs 0..119; line_busy falls after the 240th tick; underrun=0.
REQ-036 Scenario: 32 line_starts then one more, no frame_start -> line 32 reads base address 0 (wrap); line 31 base = 3720.
REQ-037 Scenario: shift_tick at t=11 after line_start at t=10 -> underrun=1 and stays 1; first nibble output is 0; the remaining nibbles are correct.
REQ-038 Scenario: line_start mid-line at nibble 57 -> underrun=1; a new read at the next line's base; no stale nibble appears on lcd_d.
REQ-039 Scenario: rst asserted at nibble 100 with a read in flight -> all outputs at reset values next clk; the following line_start reads addr 0.
